mdu_seq: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair of the MIPS core. It executes MULT, MULTU, DIV and DIVU as 32-step shift-add and restoring-divide sequences, and handles MTHI/MTLO writes. It raises a stall to the pipeline whenever an issue or HI/LO read collides with an operation in progress. It sits beside the ALU in the execute stage; the decoder drives `op`/`start` and the writeback mux reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mdu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mdu_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: 32-step shift-add
// multiply, restoring divide, MTHI/MTLO writes and pipeline stall generation.
module mdu_seq #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          rd_req,
  input  logic          flush,
  output logic          busy,
  output logic          stall,
  output logic          done,
  output logic          dz,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int         CW       = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   p_reg;
  logic [DW-1:0]   q_reg;
  logic [DW-1:0]   d_reg;
  logic [DW-1:0]   hi_reg;
  logic [DW-1:0]   lo_reg;
  logic            is_div_reg;
  logic            neg_res_reg;
  logic            neg_rem_reg;
  logic            zero_reg;
  logic            done_reg;
  logic            dz_reg;

  logic            op_mul;
  logic            op_div;
  logic            op_sgn;
  logic            issue;
  logic            div_zero;
  logic            cnt_last;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;

  logic [DW:0]     mul_sum;
  logic [DW:0]     div_shift;
  logic            div_ge;
  logic [DW-1:0]   div_rem;
  logic [2*DW-1:0] prod;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quo_fix;
  logic [DW-1:0]   rem_fix;

  always_comb begin
    op_mul   = (op == OP_MULT) || (op == OP_MULTU);
    op_div   = (op == OP_DIV) || (op == OP_DIVU);
    op_sgn   = (op == OP_MULT) || (op == OP_DIV);
    issue    = (state_reg == IDLE) && start && !flush;
    div_zero = op_div && (b == {DW{1'b0}});
    cnt_last = (cnt_reg == CW'(DW - 1));
    abs_a    = (op_sgn && a[DW-1]) ? -a : a;
    abs_b    = (op_sgn && b[DW-1]) ? -b : b;
  end

  // Datapath: one multiply or divide step per CALC cycle, sign fix-up at FINISH.
  always_comb begin
    mul_sum   = {1'b0, p_reg} + (q_reg[0] ? {1'b0, d_reg} : {(DW+1){1'b0}});
    div_shift = {p_reg, q_reg[DW-1]};
    div_ge    = (div_shift >= {1'b0, d_reg});
    div_rem   = div_shift[DW-1:0] - d_reg;
    prod      = {p_reg, q_reg};
    prod_fix  = neg_res_reg ? -prod : prod;
    quo_fix   = neg_res_reg ? -q_reg : q_reg;
    rem_fix   = neg_rem_reg ? -p_reg : p_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (issue && (op_mul || op_div)) begin
          state_next = div_zero ? FINISH : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_last) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      zero_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue) begin
            if (op == OP_MTHI) begin
              hi_reg <= a;
            end
            if (op == OP_MTLO) begin
              lo_reg <= a;
            end
            if (op_mul || op_div) begin
              cnt_reg     <= '0;
              p_reg       <= '0;
              is_div_reg  <= op_div;
              zero_reg    <= div_zero;
              neg_res_reg <= op_sgn && (a[DW-1] ^ b[DW-1]);
              neg_rem_reg <= op_sgn && a[DW-1];
              // Q holds the multiplier (b) or dividend (a); on divide-by-zero it
              // keeps the raw dividend, which becomes HI.
              q_reg       <= div_zero ? a : (op_mul ? abs_b : abs_a);
              d_reg       <= op_mul ? abs_a : abs_b;
            end
          end
        end
        CALC: begin
          if (flush) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
            if (is_div_reg) begin
              p_reg <= div_ge ? div_rem : div_shift[DW-1:0];
              q_reg <= {q_reg[DW-2:0], div_ge};
            end else begin
              p_reg <= mul_sum[DW:1];
              q_reg <= {mul_sum[0], q_reg[DW-1:1]};
            end
          end
        end
        FINISH: begin
          if (!flush) begin
            done_reg <= 1'b1;
            dz_reg   <= zero_reg;
            if (zero_reg) begin
              hi_reg <= q_reg;
              lo_reg <= {DW{1'b1}};
            end else if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else begin
              hi_reg <= prod_fix[2*DW-1:DW];
              lo_reg <= prod_fix[DW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    stall = busy && (start || rd_req);
    done  = done_reg;
    dz    = dz_reg;
    hi    = hi_reg;
    lo    = lo_reg;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: hand-computed HI/LO results, busy length,
// done/dz pulses, stall behaviour, flush and asynchronous reset.
module tb_mdu_seq;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        rd_req = 1'b0;
  logic        flush  = 1'b0;
  logic [2:0]  op     = 3'd0;
  logic [31:0] a      = 32'd0;
  logic [31:0] b      = 32'd0;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mdu_seq #(.DW(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_req (rd_req),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .dz     (dz),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic run_muldiv(input string tag, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_dz, input int exp_busy);
    int cyc;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_done_low"}, done, 64'd0);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, cyc, exp_busy);
    check_eq({tag, "_hi"}, hi, exp_hi);
    check_eq({tag, "_lo"}, lo, exp_lo);
    check_eq({tag, "_done"}, done, 64'd1);
    check_eq({tag, "_dz"}, dz, exp_dz);
    $display("%s: op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b busy=%0d",
             tag, o, x, y, hi, lo, dz, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;

    // Reset state, with issue and read requests asserted to show stall stays low.
    start  = 1'b1;
    rd_req = 1'b1;
    op     = 3'd1;
    #12;
    check_eq("rst_hi", hi, 64'd0);
    check_eq("rst_lo", lo, 64'd0);
    check_eq("rst_busy", busy, 64'd0);
    check_eq("rst_done", done, 64'd0);
    check_eq("rst_dz", dz, 64'd0);
    check_eq("rst_stall", stall, 64'd0);
    $display("reset: hi=%h lo=%h busy=%0b stall=%0b", hi, lo, busy, stall);
    start  = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back operations, each issued in the previous done cycle.
    run_muldiv("mult_m3x5",   3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
    run_muldiv("multu_max",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run_muldiv("mult_minsq",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
    run_muldiv("div_m7_2",    3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run_muldiv("divu_7_2",    3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33);
    run_muldiv("div_min_m1",  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
    run_muldiv("divu_dz",     3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1);

    // MTHI issued in the dz done cycle.
    start = 1'b1;
    op    = 3'd5;
    a     = 32'h000000AA;
    @(negedge clk);
    check_eq("mthi_hi", hi, 64'h0AA);
    check_eq("mthi_busy", busy, 64'd0);
    check_eq("mthi_dz_pulse", dz, 64'd0);
    check_eq("mthi_done_pulse", done, 64'd0);
    $display("mthi: hi=%h busy=%0b", hi, busy);

    // MULTU 3x4 with an MTLO and a HI/LO read contending while busy.
    op = 3'd2;
    a  = 32'd3;
    b  = 32'd4;
    @(negedge clk);
    op     = 3'd6;
    a      = 32'h00000055;
    rd_req = 1'b1;
    cyc    = 0;
    while (busy && cyc < 100) begin
      check_eq("contend_stall", stall, 64'd1);
      check_eq("contend_hi_hold", hi, 64'h0AA);
      check_eq("contend_lo_hold", lo, 64'hFFFFFFFF);
      cyc++;
      @(negedge clk);
    end
    check_eq("contend_busy_cycles", cyc, 64'd33);
    check_eq("contend_hi", hi, 64'd0);
    check_eq("contend_lo", lo, 64'd12);
    check_eq("contend_done", done, 64'd1);
    check_eq("contend_stall_idle", stall, 64'd0);
    $display("multu_contend: hi=%h lo=%h busy=%0d", hi, lo, cyc);
    start  = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    check_eq("contend_lo_after", lo, 64'd12);

    // Flush a DIVU at cnt == 10.
    start = 1'b1;
    op    = 3'd4;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("flush_busy_before", busy, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy_after", busy, 64'd0);
    check_eq("flush_hi", hi, 64'd0);
    check_eq("flush_lo", lo, 64'd12);
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_no_done", done, 64'd0);
      @(negedge clk);
    end
    $display("divu_flush: hi=%h lo=%h busy=%0b", hi, lo, busy);

    // Flush in the same cycle as a start drops the start.
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd5;
    a     = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("flush_mthi_hi", hi, 64'd0);
    op = 3'd1;
    a  = 32'd9;
    b  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check_eq("flush_mult_busy", busy, 64'd0);
    $display("flush_start: hi=%h busy=%0b", hi, busy);

    // Asynchronous reset in the middle of a MULT.
    start = 1'b1;
    op    = 3'd1;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start  = 1'b0;
    rd_req = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("arst_busy_before", busy, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_hi", hi, 64'd0);
    check_eq("arst_lo", lo, 64'd0);
    check_eq("arst_busy", busy, 64'd0);
    check_eq("arst_stall", stall, 64'd0);
    $display("async_reset: hi=%h lo=%h busy=%0b", hi, lo, busy);
    rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_muldiv("multu_6x7", 3'd2, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
    @(negedge clk);
    check_eq("final_done_low", done, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
